pool_win_fetch: RTL and testbench
=================================

Name: pool_win_fetch

Overview:
Upstream feeder for the pooling unit. Given a data-matrix base address, matrix size and pool size from software, it reads the matrix row-segments from memory. It assembles non-overlapping pool windows (stride equals pool size) and streams them, one window per transfer, over a valid/ready handshake to the pool datapath. Windows are emitted in row-major window order.

Parameters:
ADDR_WIDTH, 12, byte address width
MEM_DATA_BUS, 128, memory read data width (bits)
MAX_MAT_DIM, 32, max matrix rows/cols
MAX_WIN_DIM, 4, max pool rows/cols (MAX_WIN_DIM*8 <= MEM_DATA_BUS)
DIM_W, $clog2(MAX_MAT_DIM+1), matrix-dimension field width
WIN_W, $clog2(MAX_WIN_DIM+1), pool-dimension field width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sw_start  in  1  one-cycle start pulse
sw_rd_addr  in  ADDR_WIDTH  matrix base byte address, row-major, 1 byte/element
sw_rd_m  in  DIM_W  matrix rows M
sw_rd_n  in  DIM_W  matrix cols N
sw_pool_m  in  WIN_W  pool rows P
sw_pool_n  in  WIN_W  pool cols Q
busy  out  1  1 from accepted start until done
done  out  1  one-cycle pulse after last window accepted
err  out  1  sticky config error, cleared by next accepted start
mem_rd_req  out  1  read request
mem_rd_addr  out  ADDR_WIDTH  read byte address
mem_rd_gnt  in  1  request accepted this cycle
mem_rd_valid  in  1  read data valid
mem_rd_data  in  MEM_DATA_BUS  bytes from mem_rd_addr upward; byte k at bits [8k+7:8k]
win_valid  out  1  window available
win_ready  in  1  consumer accepts
win_data  out  8*MAX_WIN_DIM*MAX_WIN_DIM  byte (r,c) at index r*MAX_WIN_DIM+c; unused bytes 0
win_last  out  1  marks final window of the matrix

Behaviour:
- Reset values: busy, done, err, mem_rd_req, win_valid, win_last = 0; mem_rd_addr, win_data = 0; FSM = IDLE.
- sw_* latched on accepted start (IDLE only); start while busy is ignored.
- Window counts: WR = floor(M/P), WC = floor(N/Q). Window (wr,wc), row i: addr = base + (wr*P+i)*N + wc*Q, mod 2^ADDR_WIDTH (wraps silently).
- FSM: IDLE -start-> REQ. REQ: mem_rd_req=1 with addr held stable until mem_rd_gnt, then WAIT. WAIT: on mem_rd_valid, take bytes 0..Q-1 into window row i. If i<P-1, increment i and go to REQ; else go to OUT. OUT: win_valid=1, data/last stable until win_ready. On handshake, advance wc, then wr; go to REQ, or to DONE after the last window. DONE: done=1 for one cycle, busy drops the same cycle, then IDLE.
- Exactly one outstanding read. mem_rd_valid outside WAIT is ignored.
- Latency: mem_rd_req rises the cycle after start. win_valid rises the cycle after the final row's mem_rd_valid. The next window's request is issued the cycle after the win handshake.
- Window buffer is cleared at each window start, so bytes beyond P x Q are 0.
- WR=0 or WC=0 (including P>M or Q>N), or any of M,N,P,Q = 0: no reads, START->DONE, done pulses.
- Reset mid-operation: all state aborts to IDLE immediately; any pending memory response is dropped.

Optional Feature:
POOL_FETCH_CFG_CHECK_EN. Defined: at start, any of the following sets err and skips to DONE with no reads: M,N,P,Q zero; P>MAX_WIN_DIM; Q>MAX_WIN_DIM; M>MAX_MAT_DIM; N>MAX_MAT_DIM; P>M; Q>N. Undefined: err is tied 0 and only the zero-window rule applies; out-of-range values produce undefined window contents but the FSM still terminates.

Decomposition:
- Shared package pool_pkg: FSM state enum, byte width constant 8, window byte-index function, window-count typedefs.
- One natural sub-module: pool_win_addr_gen (wr/wc/i counters, address arithmetic, last-window detect), instantiated by the FSM top.

Test Plan:
- M=4,N=4,P=2,Q=2, base 0x100, mem returns addr-LSB bytes, win_ready=1 -> 4 windows. First window bytes {00,01,04,05} from addrs 0x100,0x104. win_last only on 4th. done pulses once.
- Same config, win_ready low 10 cycles on window 2 -> win_valid/win_data/win_last held stable; no new mem_rd_req until handshake.
- mem_rd_gnt delayed 3 cycles, mem_rd_valid 5 cycles later -> mem_rd_addr stable while req high; exactly P*WR*WC=8 requests total.
- M=5,N=7,P=2,Q=3 -> WR=2,WC=2; window (1,1) rows at base+14+3, base+21+3. Unused window bytes 0.
- P=3 > M=2 -> zero reads, done 1 cycle after start. With POOL_FETCH_CFG_CHECK_EN, err=1 until the next start.
- rst_n asserted while in WAIT, then late mem_rd_valid, then new start -> outputs at reset values, stray data ignored, new run correct.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling window fetcher.
package pool_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StOut,
        StDone
    } fetch_state_e;

    // Row-within-window counter; wide enough for any legal pool dimension.
    typedef logic [7:0] win_cnt_t;

    function automatic int unsigned win_byte_idx(input int unsigned r, input int unsigned c,
                                                 input int unsigned dim);
        return r * dim + c;
    endfunction

endpackage

// File: rtl/pool_win_addr_gen.sv
// Window/row counters and incremental read-address generation for pool_win_fetch.
module pool_win_addr_gen
    import pool_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DIM_W      = 6,
    parameter int unsigned WIN_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_init,
    input  logic                  i_row_adv,
    input  logic                  i_win_adv,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [DIM_W-1:0]      i_mat_m,
    input  logic [DIM_W-1:0]      i_mat_n,
    input  logic [WIN_W-1:0]      i_pool_m,
    input  logic [WIN_W-1:0]      i_pool_n,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output win_cnt_t              o_row_idx,
    output logic [WIN_W-1:0]      o_pool_n,
    output logic                  o_row_last,
    output logic                  o_win_last
);

    localparam int unsigned CW = DIM_W + 2;

    logic [DIM_W-1:0]      r_m, r_n;
    logic [WIN_W-1:0]      r_p, r_q;
    logic [DIM_W-1:0]      r_row, r_col;
    win_cnt_t              r_i;
    logic [ADDR_WIDTH-1:0] r_wrow_addr, r_win_addr, r_addr;

    logic [ADDR_WIDTH-1:0] w_pn, w_n_a, w_q_a;
    logic [CW-1:0]         w_col_end, w_row_end;
    logic                  w_last_col, w_last_row;

    assign w_pn  = ADDR_WIDTH'(r_p) * ADDR_WIDTH'(r_n);
    assign w_n_a = ADDR_WIDTH'(r_n);
    assign w_q_a = ADDR_WIDTH'(r_q);

    // No further window fits when start + 2*size overshoots the matrix edge.
    assign w_col_end  = CW'(r_col) + CW'(r_q) + CW'(r_q);
    assign w_row_end  = CW'(r_row) + CW'(r_p) + CW'(r_p);
    assign w_last_col = w_col_end > CW'(r_n);
    assign w_last_row = w_row_end > CW'(r_m);

    assign o_addr     = r_addr;
    assign o_row_idx  = r_i;
    assign o_pool_n   = r_q;
    assign o_row_last = (r_i == (win_cnt_t'(r_p) - win_cnt_t'(1)));
    assign o_win_last = w_last_col && w_last_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m         <= '0;
            r_n         <= '0;
            r_p         <= '0;
            r_q         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_i         <= '0;
            r_wrow_addr <= '0;
            r_win_addr  <= '0;
            r_addr      <= '0;
        end else if (i_init) begin
            r_m         <= i_mat_m;
            r_n         <= i_mat_n;
            r_p         <= i_pool_m;
            r_q         <= i_pool_n;
            r_row       <= '0;
            r_col       <= '0;
            r_i         <= '0;
            r_wrow_addr <= i_base;
            r_win_addr  <= i_base;
            r_addr      <= i_base;
        end else if (i_row_adv) begin
            r_i    <= r_i + win_cnt_t'(1);
            r_addr <= r_addr + w_n_a;
        end else if (i_win_adv) begin
            r_i <= '0;
            if (!w_last_col) begin
                r_col      <= r_col + DIM_W'(r_q);
                r_win_addr <= r_win_addr + w_q_a;
                r_addr     <= r_win_addr + w_q_a;
            end else begin
                r_col       <= '0;
                r_row       <= r_row + DIM_W'(r_p);
                r_wrow_addr <= r_wrow_addr + w_pn;
                r_win_addr  <= r_wrow_addr + w_pn;
                r_addr      <= r_wrow_addr + w_pn;
            end
        end
    end

endmodule

// File: rtl/pool_win_fetch.sv
// Fetches matrix rows and streams non-overlapping pool windows to the pool datapath.
// Optional config range checking is enabled by defining POOL_FETCH_CFG_CHECK_EN.
module pool_win_fetch
    import pool_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned MEM_DATA_BUS = 128,
    parameter int unsigned MAX_MAT_DIM  = 32,
    parameter int unsigned MAX_WIN_DIM  = 4,
    parameter int unsigned DIM_W        = $clog2(MAX_MAT_DIM + 1),
    parameter int unsigned WIN_W        = $clog2(MAX_WIN_DIM + 1),
    localparam int unsigned WIN_DATA_W  = 8 * MAX_WIN_DIM * MAX_WIN_DIM
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sw_start,
    input  logic [ADDR_WIDTH-1:0]   sw_rd_addr,
    input  logic [DIM_W-1:0]        sw_rd_m,
    input  logic [DIM_W-1:0]        sw_rd_n,
    input  logic [WIN_W-1:0]        sw_pool_m,
    input  logic [WIN_W-1:0]        sw_pool_n,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    mem_rd_req,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic                    mem_rd_gnt,
    input  logic                    mem_rd_valid,
    input  logic [MEM_DATA_BUS-1:0] mem_rd_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [WIN_DATA_W-1:0]   win_data,
    output logic                    win_last
);

    fetch_state_e          r_state;
    logic                  r_busy, r_done, r_err, r_req, r_win_valid, r_win_last;
    logic [WIN_DATA_W-1:0] r_win_data;

    logic                  w_init, w_row_adv, w_win_adv;
    logic                  w_zero, w_cfg_err, w_skip;
    logic [ADDR_WIDTH-1:0] w_addr;
    win_cnt_t              w_row_idx;
    logic [WIN_W-1:0]      w_pool_n;
    logic                  w_row_last, w_win_last;
    logic                  w_unused_data;

    assign w_unused_data = ^mem_rd_data[MEM_DATA_BUS-1:BYTE_W*MAX_WIN_DIM];

    assign w_zero = (sw_rd_m == '0) || (sw_rd_n == '0) || (sw_pool_m == '0) ||
                    (sw_pool_n == '0) || (DIM_W'(sw_pool_m) > sw_rd_m) ||
                    (DIM_W'(sw_pool_n) > sw_rd_n);

`ifdef POOL_FETCH_CFG_CHECK_EN
    localparam logic [WIN_W-1:0] WinMax = WIN_W'(MAX_WIN_DIM);
    localparam logic [DIM_W-1:0] MatMax = DIM_W'(MAX_MAT_DIM);
    assign w_cfg_err = w_zero || (sw_pool_m > WinMax) || (sw_pool_n > WinMax) ||
                       (sw_rd_m > MatMax) || (sw_rd_n > MatMax);
`else
    assign w_cfg_err = 1'b0;
`endif

    assign w_skip    = w_zero || w_cfg_err;
    assign w_init    = (r_state == StIdle) && sw_start;
    assign w_row_adv = (r_state == StWait) && mem_rd_valid && !w_row_last;
    assign w_win_adv = (r_state == StOut) && win_ready && !w_win_last;

    pool_win_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DIM_W      (DIM_W),
        .WIN_W      (WIN_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_init     (w_init),
        .i_row_adv  (w_row_adv),
        .i_win_adv  (w_win_adv),
        .i_base     (sw_rd_addr),
        .i_mat_m    (sw_rd_m),
        .i_mat_n    (sw_rd_n),
        .i_pool_m   (sw_pool_m),
        .i_pool_n   (sw_pool_n),
        .o_addr     (w_addr),
        .o_row_idx  (w_row_idx),
        .o_pool_n   (w_pool_n),
        .o_row_last (w_row_last),
        .o_win_last (w_win_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_req       <= 1'b0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_win_data  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (sw_start) begin
                        r_err      <= w_cfg_err;
                        r_win_data <= '0;
                        if (w_skip) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= StReq;
                            r_req   <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (mem_rd_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (mem_rd_valid) begin
                        // Out-of-range rows/cols are dropped so oversized pools cannot overrun.
                        for (int r = 0; r < int'(MAX_WIN_DIM); r++) begin
                            for (int c = 0; c < int'(MAX_WIN_DIM); c++) begin
                                if ((w_row_idx == win_cnt_t'(r)) && (c < int'(w_pool_n))) begin
                                    r_win_data[win_byte_idx(r, c, MAX_WIN_DIM)*BYTE_W +: BYTE_W]
                                        <= mem_rd_data[c*BYTE_W +: BYTE_W];
                                end
                            end
                        end
                        if (w_row_last) begin
                            r_state     <= StOut;
                            r_win_valid <= 1'b1;
                            r_win_last  <= w_win_last;
                        end else begin
                            r_state <= StReq;
                            r_req   <= 1'b1;
                        end
                    end
                end
                StOut: begin
                    if (win_ready) begin
                        r_win_valid <= 1'b0;
                        r_win_last  <= 1'b0;
                        r_win_data  <= '0;
                        if (w_win_last) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= StReq;
                            r_req   <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign mem_rd_req  = r_req;
    assign mem_rd_addr = w_addr;
    assign win_valid   = r_win_valid;
    assign win_last    = r_win_last;
    assign win_data    = r_win_data;

endmodule

// File: tb/tb_pool_win_fetch.sv
// Directed bench for pool_win_fetch with a latency-programmable memory responder.
module tb_pool_win_fetch;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sw_start;
    logic [11:0]  sw_rd_addr;
    logic [5:0]   sw_rd_m, sw_rd_n;
    logic [2:0]   sw_pool_m, sw_pool_n;
    logic         busy, done, err;
    logic         mem_rd_req;
    logic [11:0]  mem_rd_addr;
    logic         mem_rd_gnt, mem_rd_valid;
    logic [127:0] mem_rd_data;
    logic         win_valid, win_ready, win_last;
    logic [127:0] win_data;

    pool_win_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_start     (sw_start),
        .sw_rd_addr   (sw_rd_addr),
        .sw_rd_m      (sw_rd_m),
        .sw_rd_n      (sw_rd_n),
        .sw_pool_m    (sw_pool_m),
        .sw_pool_n    (sw_pool_n),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .mem_rd_req   (mem_rd_req),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_gnt   (mem_rd_gnt),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .win_data     (win_data),
        .win_last     (win_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int gnt_dly = 0, val_dly = 0;
    int nreq = 0, addr_bad = 0, done_cnt = 0, nvalid = 0;
    bit pend = 0, req_active = 0;
    int wcnt = 0, vcnt = 0;
    logic [11:0] paddr, req_addr;
    logic [127:0] cap_data [16];
    logic         cap_last [16];
    logic         cap_ra   [16];
`ifdef POOL_FETCH_CFG_CHECK_EN
    logic exp_err = 1'b1;
`else
    logic exp_err = 1'b0;
`endif

    function automatic logic [127:0] mk_data(input logic [11:0] a);
        logic [127:0] d;
        for (int k = 0; k < 16; k++) d[k*8 +: 8] = 8'(int'(a) + k);
        return d;
    endfunction

    function automatic logic [127:0] exp_win(input int base, input int n, input int p,
                                             input int q, input int wr, input int wc);
        logic [127:0] v;
        int a;
        v = '0;
        for (int i = 0; i < p; i++)
            for (int c = 0; c < q; c++) begin
                a = base + (wr * p + i) * n + wc * q + c;
                v[(i*4+c)*8 +: 8] = a[7:0];
            end
        return v;
    endfunction

    // Memory responder: one grant per request after gnt_dly, data val_dly+1 cycles later.
    always @(negedge clk) begin
        mem_rd_gnt = 1'b0;
        mem_rd_valid = 1'b0;
        if (pend) begin
            if (vcnt == 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data = mk_data(paddr);
                pend = 0;
                nvalid++;
            end else vcnt--;
        end
        if (!mem_rd_req) begin
            req_active = 0;
            wcnt = 0;
        end else begin
            if (req_active && mem_rd_addr !== req_addr) addr_bad++;
            if (!req_active) begin
                req_active = 1;
                req_addr = mem_rd_addr;
            end
            if (wcnt >= gnt_dly) begin
                mem_rd_gnt = 1'b1;
                pend = 1;
                vcnt = val_dly;
                paddr = mem_rd_addr;
                nreq++;
                wcnt = 0;
                req_active = 0;
            end else wcnt++;
        end
    end

    always @(posedge clk) if (done) done_cnt++;

    task automatic do_start(input logic [11:0] base, input int m, input int n,
                            input int p, input int q);
        @(negedge clk);
        sw_rd_addr = base;
        sw_rd_m = 6'(m);
        sw_rd_n = 6'(n);
        sw_pool_m = 3'(p);
        sw_pool_n = 3'(q);
        sw_start = 1'b1;
        @(negedge clk);
        sw_start = 1'b0;
    endtask

    // Records every accepted window until done; optionally stalls one window.
    task automatic capture(input int stall_idx, input int stall_cyc, output int ncap,
                           output int unstable, output bit tmo);
        int stall_left;
        bit pend_ra, fin, holding;
        logic [127:0] hold_d;
        logic hold_l;
        stall_left = stall_cyc;
        pend_ra = 0;
        fin = 0;
        holding = 0;
        ncap = 0;
        unstable = 0;
        win_ready = 1'b1;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            @(negedge clk);
            if (pend_ra && ncap <= 16) cap_ra[ncap-1] = mem_rd_req;
            pend_ra = 0;
            if (done) fin = 1;
            else if (win_valid) begin
                if (ncap == stall_idx && stall_left > 0) begin
                    if (!holding) begin
                        hold_d = win_data;
                        hold_l = win_last;
                        holding = 1;
                    end else if (win_data !== hold_d || win_last !== hold_l) unstable++;
                    if (mem_rd_req) unstable++;
                    win_ready = 1'b0;
                    stall_left--;
                end else begin
                    if (holding && ncap == stall_idx && win_data !== hold_d) unstable++;
                    win_ready = 1'b1;
                    if (ncap < 16) begin
                        cap_data[ncap] = win_data;
                        cap_last[ncap] = win_last;
                    end
                    ncap++;
                    pend_ra = 1;
                end
            end
        end
        tmo = !fin;
        win_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, err, mem_rd_req, win_valid, win_last} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, done, err, mem_rd_req, win_valid, win_last});
        end
        n_cmp++;
        if (mem_rd_addr !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want 000", mem_rd_addr);
        end
        n_cmp++;
        if (win_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_win_data: got %h want 0", win_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, mem_rd_req, win_valid} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want 000", {busy, mem_rd_req, win_valid});
        end
    endtask

    task automatic test_basic();
        int ncap, unst, d0, r0;
        bit tmo;
        gnt_dly = 0;
        val_dly = 0;
        d0 = done_cnt;
        r0 = nreq;
        do_start(12'h100, 4, 4, 2, 2);
        n_cmp++;
        if ({busy, mem_rd_req} !== 2'b11 || mem_rd_addr !== 12'h100) begin
            n_fail++;
            $display("FAIL basic_first_req: got busy/req %b addr %h want 11 100",
                     {busy, mem_rd_req}, mem_rd_addr);
        end
        capture(-1, 0, ncap, unst, tmo);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (tmo || ncap != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d windows (timeout %0d) want 4", ncap, tmo);
        end
        n_cmp++;
        if (cap_data[0] !== 128'h0000_0000_0000_0000_0000_0504_0000_0100) begin
            n_fail++;
            $display("FAIL basic_win0: got %h want ...0504_0000_0100", cap_data[0]);
        end
        for (int k = 1; k < 4; k++) begin
            n_cmp++;
            if (cap_data[k] !== exp_win(12'h100, 4, 2, 2, k / 2, k % 2)) begin
                n_fail++;
                $display("FAIL basic_win%0d: got %h want %h", k, cap_data[k],
                         exp_win(12'h100, 4, 2, 2, k / 2, k % 2));
            end
        end
        n_cmp++;
        if ({cap_last[0], cap_last[1], cap_last[2], cap_last[3]} !== 4'b0001) begin
            n_fail++;
            $display("FAIL basic_last: got %b want 0001",
                     {cap_last[0], cap_last[1], cap_last[2], cap_last[3]});
        end
        n_cmp++;
        if ({cap_ra[0], cap_ra[1], cap_ra[2], cap_ra[3]} !== 4'b1110) begin
            n_fail++;
            $display("FAIL basic_req_after_hs: got %b want 1110",
                     {cap_ra[0], cap_ra[1], cap_ra[2], cap_ra[3]});
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || nreq - r0 != 8 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_reqs: got done %0d reqs %0d busy %b want 1 8 0",
                     done_cnt - d0, nreq - r0, busy);
        end
    endtask

    task automatic test_stall();
        int ncap, unst;
        bit tmo;
        do_start(12'h100, 4, 4, 2, 2);
        capture(1, 10, ncap, unst, tmo);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (tmo || ncap != 4 || unst != 0) begin
            n_fail++;
            $display("FAIL stall_hold: got windows %0d unstable %0d want 4 0", ncap, unst);
        end
        n_cmp++;
        if (cap_data[1] !== 128'h0000_0000_0000_0000_0000_0706_0000_0302 || cap_ra[1] !== 1'b1)
        begin
            n_fail++;
            $display("FAIL stall_win1: got %h req %b want ...0706_0000_0302 1",
                     cap_data[1], cap_ra[1]);
        end
    endtask

    task automatic test_slow_mem();
        int ncap, unst, r0, a0;
        bit tmo;
        gnt_dly = 3;
        val_dly = 4;
        r0 = nreq;
        a0 = addr_bad;
        do_start(12'h100, 4, 4, 2, 2);
        capture(-1, 0, ncap, unst, tmo);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (tmo || ncap != 4 || nreq - r0 != 8 || addr_bad != a0) begin
            n_fail++;
            $display("FAIL slow_reqs: got win %0d reqs %0d addr_moves %0d want 4 8 0",
                     ncap, nreq - r0, addr_bad - a0);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cap_data[k] !== exp_win(12'h100, 4, 2, 2, k / 2, k % 2)) begin
                n_fail++;
                $display("FAIL slow_win%0d: got %h want %h", k, cap_data[k],
                         exp_win(12'h100, 4, 2, 2, k / 2, k % 2));
            end
        end
        gnt_dly = 0;
        val_dly = 0;
    endtask

    task automatic test_zero_windows();
        int r0, d0;
        r0 = nreq;
        d0 = done_cnt;
        do_start(12'h100, 4, 0, 2, 2);
        n_cmp++;
        if ({done, mem_rd_req} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_n_done: got done/req %b want 10", {done, mem_rd_req});
        end
        do_start(12'h100, 2, 4, 3, 2);
        n_cmp++;
        if ({done, mem_rd_req, err} !== {2'b10, exp_err}) begin
            n_fail++;
            $display("FAIL zero_p_gt_m: got done/req/err %b want 10%b",
                     {done, mem_rd_req, err}, exp_err);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (err !== exp_err || nreq != r0 || done_cnt - d0 != 2) begin
            n_fail++;
            $display("FAIL zero_sticky: got err %b reqs %0d dones %0d want %b 0 2",
                     err, nreq - r0, done_cnt - d0, exp_err);
        end
    endtask

    task automatic test_odd_dims();
        int ncap, unst;
        bit tmo;
        do_start(12'h100, 5, 7, 2, 3);
        n_cmp++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_err_clear: got %b want 0", err);
        end
        capture(-1, 0, ncap, unst, tmo);
        n_cmp++;
        if (tmo || ncap != 4) begin
            n_fail++;
            $display("FAIL odd_count: got %0d want 4", ncap);
        end
        n_cmp++;
        if (cap_data[3] !== 128'h0000_0000_0000_0000_001A_1918_0013_1211) begin
            n_fail++;
            $display("FAIL odd_win11: got %h want ...001A_1918_0013_1211", cap_data[3]);
        end
        n_cmp++;
        if (cap_data[0] !== exp_win(12'h100, 7, 2, 3, 0, 0) ||
            {cap_last[0], cap_last[1], cap_last[2], cap_last[3]} !== 4'b0001) begin
            n_fail++;
            $display("FAIL odd_win00_last: got %h last %b want %h 0001", cap_data[0],
                     {cap_last[0], cap_last[1], cap_last[2], cap_last[3]},
                     exp_win(12'h100, 7, 2, 3, 0, 0));
        end
    endtask

    task automatic test_mid_reset();
        int ncap, unst, r0, v0, stray;
        bit tmo;
        val_dly = 6;
        r0 = nreq;
        do_start(12'h100, 4, 4, 2, 2);
        for (int i = 0; i < 20 && nreq == r0; i++) @(negedge clk);
        @(negedge clk);
        v0 = nvalid;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, mem_rd_req, win_valid, win_last} !== 5'b0 || mem_rd_addr !== 12'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b addr %h want 00000 000",
                     {busy, done, mem_rd_req, win_valid, win_last}, mem_rd_addr);
        end
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || win_valid || mem_rd_req || done) stray++;
        end
        n_cmp++;
        if (stray != 0 || nvalid == v0) begin
            n_fail++;
            $display("FAIL midrst_stray: got active cycles %0d late responses %0d want 0 1",
                     stray, nvalid - v0);
        end
        val_dly = 0;
        do_start(12'h230, 4, 4, 2, 2);
        capture(-1, 0, ncap, unst, tmo);
        n_cmp++;
        if (tmo || ncap != 4 ||
            cap_data[0] !== 128'h0000_0000_0000_0000_0000_3534_0000_3130) begin
            n_fail++;
            $display("FAIL midrst_rerun: got %0d windows win0 %h want 4 ...3534_0000_3130",
                     ncap, cap_data[0]);
        end
    endtask

    initial begin
        sw_start = 1'b0;
        sw_rd_addr = '0;
        sw_rd_m = '0;
        sw_rd_n = '0;
        sw_pool_m = '0;
        sw_pool_n = '0;
        win_ready = 1'b1;
        mem_rd_gnt = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data = '0;
        test_reset();
        test_basic();
        test_stall();
        test_slow_mem();
        test_zero_windows();
        test_odd_dims();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
